// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: state codes, opcodes, ALUOp codes and opcode decode helpers
package multicycle_control_fsm_pkg;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXE    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXE    = 4'd10,
    S_IWB     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  function automatic state_t decode_op(input logic [5:0] op);
    case (op)
      OP_RTYPE:                         return S_REXE;
      OP_LW, OP_SW:                     return S_MEMADR;
      OP_BEQ, OP_BNE:                   return S_BRANCH;
      OP_J:                             return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return S_IEXE;
      default:                          return S_ILLEGAL;
    endcase
  endfunction
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 8-bit wait counter with clear, count enable and terminal-count flag
module mem_wait_timer #(
  parameter int TC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);
  logic [7:0] r_count;
  always_ff @(posedge clk) begin
    if (reset || i_clear) r_count <= 8'd0;
    else if (i_en) r_count <= r_count + 8'd1;
  end
  assign o_tc = r_count == 8'(TC);
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS control sequencer with memory-wait timeout and retire/cycle counters
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 15,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               OP,
  input  logic                     MemReady,
  output logic                     PCWrite,
  output logic                     PCWriteCondEQ,
  output logic                     PCWriteCondNE,
  output logic                     IorD,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     MemtoReg,
  output logic                     RegDst,
  output logic                     RegWrite,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [2:0]               ALUOp,
  output logic [1:0]               PCSource,
  output logic                     BusError,
  output logic                     IllegalOp,
  output logic [3:0]               State,
  output logic [COUNTER_WIDTH-1:0] RetiredCount,
  output logic [COUNTER_WIDTH-1:0] CycleCount
);
  state_t                   r_state;
  state_t                   w_next;
  logic [COUNTER_WIDTH-1:0] r_retired;
  logic [COUNTER_WIDTH-1:0] r_cycles;
  logic                     w_wait;
  logic                     w_tc;
  logic                     w_retire;
  assign w_wait = r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR;
  // timer only runs while stalled in a memory state, so any other cycle leaves it at zero for the next entry
  mem_wait_timer #(.TC(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (!w_wait || MemReady || w_tc),
    .i_en    (w_wait && !MemReady),
    .o_tc    (w_tc)
  );
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = ALU_ADD;
    PCSource      = 2'b00;
    BusError      = 1'b0;
    IllegalOp     = 1'b0;
    w_retire      = 1'b0;
    w_next        = r_state;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead  = 1'b1;
          ALUSrcB  = 2'b01;
          IRWrite  = MemReady;
          PCWrite  = MemReady;
          BusError = !MemReady && w_tc;
          w_next   = MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          w_next  = decode_op(OP);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          w_next  = OP == OP_SW ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead  = 1'b1;
          IorD     = 1'b1;
          BusError = !MemReady && w_tc;
          w_next   = MemReady ? S_MEMWB : w_tc ? S_FETCH : S_MEMRD;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          BusError = !MemReady && w_tc;
          w_retire = MemReady;
          w_next   = MemReady || w_tc ? S_FETCH : S_MEMWR;
        end
        S_REXE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_RTYPE;
          w_next  = S_RWB;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA       = 1'b1;
          ALUOp         = ALU_SUB;
          PCSource      = 2'b01;
          PCWriteCondEQ = OP == OP_BEQ;
          PCWriteCondNE = OP == OP_BNE;
          w_retire      = 1'b1;
          w_next        = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_IEXE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = imm_aluop(OP);
          w_next  = S_IWB;
        end
        S_IWB: begin
          RegWrite = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_ILLEGAL: begin
          IllegalOp = 1'b1;
          w_next    = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_cycles  <= '0;
    end else begin
      r_state  <= w_next;
      r_cycles <= r_cycles + COUNTER_WIDTH'(1);
      if (w_retire) r_retired <= r_retired + COUNTER_WIDTH'(1);
    end
  end
  assign State        = r_state;
  assign RetiredCount = r_retired;
  assign CycleCount   = r_cycles;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: scoreboard bench for the multi-cycle control sequencer
module tb_multicycle_control_fsm;
  typedef struct packed {
    logic pcw, eq, ne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcs;
    logic berr, ill;
  } ctrl_t;
  typedef struct {
    int    st;
    ctrl_t c;
    bit    chk_st;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OP;
  logic        MemReady;
  logic        PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, BusError, IllegalOp;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  State;
  logic [31:0] RetiredCount, CycleCount;
  ctrl_t       got;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_cyc = 0;
  int          exp_ret = 0;
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .BusError(BusError),
    .IllegalOp(IllegalOp), .State(State), .RetiredCount(RetiredCount), .CycleCount(CycleCount)
  );
  always #5 clk = ~clk;
  assign got = '{PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BusError, IllegalOp};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask
  function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op, input logic rdy, input logic ab);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; c.berr = ab; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; c.berr = ab; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = 1; c.iord = 1; c.berr = ab; end
      6:  begin c.srca = 1; c.aluop = 3'b111; end
      7:  begin c.rw = 1; c.rdst = 1; end
      8:  begin c.srca = 1; c.aluop = 3'b001; c.pcs = 2'b01; c.eq = op == 6'h04; c.ne = op == 6'h05; end
      9:  begin c.pcw = 1; c.pcs = 2'b10; end
      10: begin
        c.srca = 1; c.srcb = 2'b10;
        c.aluop = op == 6'h0C ? 3'b011 : op == 6'h0D ? 3'b010 : op == 6'h0F ? 3'b100 : 3'b000;
      end
      11: c.rw = 1;
      12: c.ill = 1;
      default: c = '0;
    endcase
    return c;
  endfunction
  task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy, input int st, input logic ab);
    exp_t e;
    reset = rst;
    OP = op;
    MemReady = rdy;
    sb.push_back('{st, rst ? ctrl_t'('0) : exp_ctrl(st, op, rdy, ab), !rst});
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk_st) check("state", 32'(State), 32'(e.st));
    check(rst ? "reset_ctrl" : "ctrl", 32'(got), 32'(e.c));
    if (!rst) begin
      check("cycles", CycleCount, 32'(exp_cyc));
      check("retired", RetiredCount, 32'(exp_ret));
    end
    if (rst) begin
      exp_cyc = 0;
      exp_ret = 0;
    end else begin
      exp_cyc++;
      if (st inside {4, 7, 8, 9, 11} || (st == 5 && rdy)) exp_ret++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [5:0] op, input int seq[$]);
    foreach (seq[i]) cyc(1'b0, op, 1'b1, seq[i], 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b1, 6'h00, 1'b1, 0, 1'b0);
    run(6'h00, '{0, 1, 6, 7});
    run(6'h23, '{0, 1, 2});
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'h23, 1'b0, 3, 1'b0);
    run(6'h23, '{3, 4});
    run(6'h04, '{0, 1, 8});
    run(6'h05, '{0, 1, 8});
    for (int i = 0; i < 15; i++) cyc(1'b0, 6'h02, 1'b0, 0, 1'b0);
    cyc(1'b0, 6'h02, 1'b0, 0, 1'b1);
    run(6'h02, '{0, 1, 9});
    for (int i = 0; i < 15; i++) cyc(1'b0, 6'h08, 1'b0, 0, 1'b0);
    run(6'h08, '{0, 1, 10, 11});
    run(6'h2B, '{0, 1, 2});
    for (int i = 0; i < 15; i++) cyc(1'b0, 6'h2B, 1'b0, 5, 1'b0);
    run(6'h2B, '{5});
    run(6'h2B, '{0, 1, 2});
    for (int i = 0; i < 15; i++) cyc(1'b0, 6'h2B, 1'b0, 5, 1'b0);
    cyc(1'b0, 6'h2B, 1'b0, 5, 1'b1);
    run(6'h3F, '{0, 1, 12});
    run(6'h0C, '{0, 1, 10, 11});
    run(6'h0D, '{0, 1, 10, 11});
    run(6'h0F, '{0, 1, 10, 11});
    run(6'h23, '{0, 1, 2});
    for (int i = 0; i < 15; i++) cyc(1'b0, 6'h23, 1'b0, 3, 1'b0);
    cyc(1'b0, 6'h23, 1'b0, 3, 1'b1);
    run(6'h2B, '{0, 1, 2});
    cyc(1'b0, 6'h2B, 1'b0, 5, 1'b0);
    cyc(1'b1, 6'h2B, 1'b1, 5, 1'b0);
    run(6'h00, '{0, 1, 6, 7, 0});
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
